// File: rtl/writeback_dp_pkg.sv
// Shared types for the writeback stage: the machine word, register index,
// result-source select, load funct3 encodings and the writeback FSM states.
package writeback_dp_pkg;

  typedef logic signed [31:0] word_st;
  typedef logic        [31:0] word_32ut;
  typedef logic        [4:0]  reg_e;

  localparam reg_e REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_e;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd4,
    LHU = 3'd5
  } load_f3_e;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

endpackage

// File: rtl/writeback_dp_load_extend.sv
// Load alignment and extension: picks the byte/half/word addressed by the low
// address bits out of an aligned memory word and flags misaligned or
// unsupported load encodings.
module load_extend
  import writeback_dp_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o,
  output logic        err_o
);

  word_32ut byteShift;
  word_32ut halfShift;
  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  // Lane selection followed by sign/zero extension according to funct3.
  always_comb begin
    byteShift = rdata_i >> {off_i, 3'b000};
    halfShift = rdata_i >> {off_i[1], 4'b0000};
    byteVal   = byteShift[7:0];
    halfVal   = halfShift[15:0];
    data_o    = 32'd0;
    err_o     = 1'b0;
    case (funct3_i)
      LB:  data_o = {{24{byteVal[7]}}, byteVal};
      LBU: data_o = {24'd0, byteVal};
      LH: begin
        data_o = {{16{halfVal[15]}}, halfVal};
        err_o  = off_i[0];
      end
      LHU: begin
        data_o = {16'd0, halfVal};
        err_o  = off_i[0];
      end
      LW: begin
        data_o = rdata_i;
        err_o  = (off_i != 2'b00);
      end
      default: begin
        data_o = 32'd0;
        err_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/writeback_dp.sv
// Writeback stage: waits for load data when needed, aligns/extends it, picks
// the result and drives the registered register-file write port. Also stalls
// upstream while a load is outstanding and counts retired instructions.
module writeback_dp
  import writeback_dp_pkg::*;
#(
  parameter int INSTRET_W = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_wb_i,
  input  logic                 reg_write_wb_i,
  input  logic [4:0]           rd_a_wb_i,
  input  logic [1:0]           result_src_wb_i,
  input  logic [2:0]           funct3_wb_i,
  input  logic [31:0]          alu_result_wb_i,
  input  logic [31:0]          pc_next_4_wb_i,
  input  logic                 mem_rvalid_i,
  input  logic [31:0]          mem_rdata_i,
  output logic                 mem_rready_o,
  output logic                 stall_wb_o,
  output logic                 rd_we_wb_o,
  output logic [4:0]           rd_a_wb_o,
  output logic [31:0]          rd_d_wb_o,
  output logic                 err_wb_o,
  output logic [INSTRET_W-1:0] instret_o
);

  wb_state_e state_q, state_d;

  reg_e       capRd_q;
  logic       capWe_q;
  logic [2:0] capF3_q;
  logic [1:0] capOff_q;

  logic       isLoad;
  logic       commit;
  logic       useMem;
  logic       selWe;
  reg_e       selRd;
  logic [2:0] selF3;
  logic [1:0] selOff;
  word_32ut   ldData;
  logic       ldErr;
  logic       commitErr;
  word_32ut   result;

  logic                 rdWe_q;
  reg_e                 rdA_q;
  word_32ut             rdD_q;
  logic                 err_q;
  logic [INSTRET_W-1:0] instret_q;

  assign isLoad = valid_wb_i && (result_src_wb_i == RES_MEM);

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: park in WAIT_MEM only when a load misses its response.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (isLoad && !mem_rvalid_i) state_d = WAIT_MEM;
      WAIT_MEM: if (mem_rvalid_i)            state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM outputs: handshake, stall, commit strobe and which fields to retire.
  always_comb begin
    commit       = 1'b0;
    useMem       = 1'b0;
    mem_rready_o = 1'b0;
    stall_wb_o   = 1'b0;
    selWe        = reg_write_wb_i;
    selRd        = rd_a_wb_i;
    selF3        = funct3_wb_i;
    selOff       = alu_result_wb_i[1:0];
    unique case (state_q)
      IDLE: begin
        if (isLoad) begin
          useMem       = 1'b1;
          mem_rready_o = 1'b1;
          stall_wb_o   = !mem_rvalid_i;
          commit       = mem_rvalid_i;
        end else if (valid_wb_i) begin
          commit = 1'b1;
        end
      end
      WAIT_MEM: begin
        useMem       = 1'b1;
        mem_rready_o = 1'b1;
        stall_wb_o   = !mem_rvalid_i;
        commit       = mem_rvalid_i;
        selWe        = capWe_q;
        selRd        = capRd_q;
        selF3        = capF3_q;
        selOff       = capOff_q;
      end
      default: ;
    endcase
  end

  load_extend u_load_extend (
    .funct3_i (selF3),
    .off_i    (selOff),
    .rdata_i  (mem_rdata_i),
    .data_o   (ldData),
    .err_o    (ldErr)
  );

  // Result mux; the unused source encoding falls back to the ALU result.
  always_comb begin
    commitErr = useMem && ldErr;
    if (useMem)                              result = ldData;
    else if (result_src_wb_i == RES_PC4)     result = pc_next_4_wb_i;
    else                                     result = alu_result_wb_i;
  end

  // Remember the load's destination and alignment while memory is slow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      capRd_q  <= REG_ZERO;
      capWe_q  <= 1'b0;
      capF3_q  <= 3'd0;
      capOff_q <= 2'd0;
    end else if (state_q == IDLE && isLoad && !mem_rvalid_i) begin
      capRd_q  <= rd_a_wb_i;
      capWe_q  <= reg_write_wb_i;
      capF3_q  <= funct3_wb_i;
      capOff_q <= alu_result_wb_i[1:0];
    end
  end

  // Registered write port, error pulse and retire counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdWe_q    <= 1'b0;
      rdA_q     <= REG_ZERO;
      rdD_q     <= 32'd0;
      err_q     <= 1'b0;
      instret_q <= '0;
    end else if (commit) begin
      rdWe_q    <= selWe && (selRd != REG_ZERO) && !commitErr;
      rdA_q     <= selRd;
      rdD_q     <= result;
      err_q     <= commitErr;
      instret_q <= instret_q + INSTRET_W'(1);
    end else begin
      rdWe_q <= 1'b0;
      err_q  <= 1'b0;
    end
  end

  assign rd_we_wb_o = rdWe_q;
  assign rd_a_wb_o  = rdA_q;
  assign rd_d_wb_o  = rdD_q;
  assign err_wb_o   = err_q;
  assign instret_o  = instret_q;

endmodule
